bsg_manycore_axi_mem_arbiter: RTL
=================================

# bsg_manycore_axi_mem_arbiter

Round-robin scheduler that shares a single AXI4 memory slave (the manycore testbench DRAM model) among `num_clients_p` requesters. Each requester issues whole-burst read or write requests over a simple valid/ready interface. The arbiter serialises them into AXI AR/R or AW/W/B transactions with exactly one transaction outstanding at a time. It sits between the cache/DMA-side request ports and the AXI memory port.

## Interface
Parameters:
- `num_clients_p`, 4, number of requesters (≥2)
- `axi_id_width_p`, 6, AXI ID width (≥ clog2(num_clients_p))
- `axi_addr_width_p`, 64, byte address width
- `axi_data_width_p`, 256, beat width (multiple of 32)
- `axi_burst_len_p`, 2, beats per transaction (≥1, power of 2)

Ports:
- `clk_i` in 1 clock
- `reset_i` in 1 reset; **asynchronous, active-high**
- `req_v_i` in N per-client request valid
- `req_we_i` in N 1 = write, 0 = read
- `req_addr_i` in N×addr per-client burst start address
- `req_ready_o` out N one-hot request accept
- `wdata_v_i` in N per-client write-beat valid
- `wdata_i` in N×data per-client write beat
- `wdata_ready_o` out N per-client write-beat accept
- `rdata_v_o` out N per-client read-beat valid
- `rdata_o` out data read beat, broadcast to all clients
- `rdata_ready_i` in N per-client read-beat ready
- `wr_done_o` out N one-cycle write-completion pulse
- `error_o` out 1 sticky protocol/response error
- AXI master: `axi_aw{id,addr,len,size,burst,valid}_o`, `axi_awready_i`, `axi_w{data,strb,last,valid}_o`, `axi_wready_i`, `axi_b{id,resp,valid}_i`, `axi_bready_o`, `axi_ar{id,addr,len,size,burst,valid}_o`, `axi_arready_i`, `axi_r{id,data,resp,last,valid}_i`, `axi_rready_o`; widths per AXI4 and the parameters above.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- **IDLE (arbitration):** if any `req_v_i` is set, grant the first requesting client at or after `last_r+1` (wrapping).
  - Assert `req_ready_o[g]` combinationally in the same cycle.
  - Latch `g`, `req_we_i[g]` and `req_addr_i[g]`, and set `last_r <= g`.
  - Next state is WR_ADDR if `we` is set, otherwise RD_ADDR.
- **Constant AXI fields:**
  - id = g zero-extended.
  - len = `axi_burst_len_p-1`.
  - size = clog2(data_width/8).
  - burst = 2'b01 (INCR).
  - wstrb = all ones.
  - resp outputs are ignored except for the error check below.
- **RD_ADDR:** `axi_arvalid_o=1`. On `axi_arready_i`, go to RD_DATA with beat count = 0.
- **RD_DATA:**
  - `rdata_v_o[g]=axi_rvalid_i`, `axi_rready_o=rdata_ready_i[g]`, `rdata_o=axi_rdata_i`.
  - Count increments on each beat handshake.
  - On a handshake with `axi_rlast_i`, return to IDLE.
- **WR_ADDR:** `axi_awvalid_o=1`. On `axi_awready_i`, go to WR_DATA with count = 0.
- **WR_DATA:**
  - `axi_wvalid_o=wdata_v_i[g]`, `wdata_ready_o[g]=axi_wready_i`, `axi_wdata_o=wdata_i[g]`.
  - `axi_wlast_o=(count==burst_len-1)`.
  - A handshake while wlast is high moves to WR_RESP.
- **WR_RESP:** `axi_bready_o=1`. On `axi_bvalid_i`, pulse `wr_done_o[g]` for that cycle and return to IDLE.
- **Error (sticky until reset):** `error_o` sets on any of:
  - a non-zero rresp or bresp;
  - rid or bid ≠ g;
  - `axi_rlast_i` disagreeing with count==burst_len-1.
- Signals to non-granted clients are always 0.

## Timing
- **Reset:** asynchronous assert. State → IDLE, `last_r` → num_clients_p-1 (client 0 has first priority), count → 0, `error_o` → 0.
  - All outputs are 0 during reset: every valid, ready and done is 0, and AXI address/data outputs are 0.
- **Reset mid-transaction:** abandon immediately with no completion pulse. The slave must also be reset.
- **Accept-to-AXI latency:** a request accepted in cycle t presents arvalid/awvalid in cycle t+1.
- **Serialisation:** no new grant until the current transaction completes. A read completes on its last R beat; a write completes on B. The next grant is possible in the cycle after return to IDLE.
- **Stability:** address and ID outputs hold stable while valid is high. No combinational path runs from an AXI ready input to the matching AXI valid output.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Losers keep `req_v_i` high and are not accepted.
- **Back-pressure:** stalled beats hold the count. `axi_burst_len_p=1` is legal: the first beat carries rlast/wlast.
- **Count width:** clog2(burst_len) bits; it wraps to 0 only via state exit.

## Test plan
- Reset, then client 2 reads 0x1000 with burst_len=2 → arvalid in cycle 1 with arid=2, araddr=0x1000, arlen=1. Two beats reach `rdata_v_o[2]`, the second with rlast. State returns to IDLE and `error_o` stays 0.
- Client 1 writes two beats 0xA…, 0xB… to 0x2000, then client 0 reads 0x2000 → read data matches the written data. `wr_done_o[1]` pulses exactly once, after B.
- All 4 clients request reads continuously → grant order 0,1,2,3,0,…, with no client granted twice before the others are served.
- Hold `rdata_ready_i[g]=0` for 5 cycles mid-burst → `axi_rready_o` stays 0, no beats are lost, and the count holds.
- Slave returns rresp=2'b10 on one beat → `error_o` goes to 1 and stays 1 until reset. The transaction still completes.
- Assert `reset_i` in WR_DATA after 1 beat → outputs are 0 asynchronously, and after release client 0 has priority.

Source files
------------

// File: rtl/bsg_manycore_axi_mem_arbiter.sv
// Round-robin arbiter sharing one AXI4 memory slave among several burst requesters.
// Exactly one AXI transaction is in flight at a time; requests are accepted only in idle.
module bsg_manycore_axi_mem_arbiter #(
  parameter int unsigned num_clients_p    = 4,
  parameter int unsigned axi_id_width_p   = 6,
  parameter int unsigned axi_addr_width_p = 64,
  parameter int unsigned axi_data_width_p = 256,
  parameter int unsigned axi_burst_len_p  = 2
) (
  input  logic                                             clk_i,
  input  logic                                             reset_i,

  // client request side
  input  logic [num_clients_p-1:0]                         req_v_i,
  input  logic [num_clients_p-1:0]                         req_we_i,
  input  logic [num_clients_p-1:0][axi_addr_width_p-1:0]   req_addr_i,
  output logic [num_clients_p-1:0]                         req_ready_o,
  input  logic [num_clients_p-1:0]                         wdata_v_i,
  input  logic [num_clients_p-1:0][axi_data_width_p-1:0]   wdata_i,
  output logic [num_clients_p-1:0]                         wdata_ready_o,
  output logic [num_clients_p-1:0]                         rdata_v_o,
  output logic [axi_data_width_p-1:0]                      rdata_o,
  input  logic [num_clients_p-1:0]                         rdata_ready_i,
  output logic [num_clients_p-1:0]                         wr_done_o,
  output logic                                             error_o,

  // AXI write address
  output logic [axi_id_width_p-1:0]                        axi_awid_o,
  output logic [axi_addr_width_p-1:0]                      axi_awaddr_o,
  output logic [7:0]                                       axi_awlen_o,
  output logic [2:0]                                       axi_awsize_o,
  output logic [1:0]                                       axi_awburst_o,
  output logic                                             axi_awvalid_o,
  input  logic                                             axi_awready_i,
  // AXI write data
  output logic [axi_data_width_p-1:0]                      axi_wdata_o,
  output logic [axi_data_width_p/8-1:0]                    axi_wstrb_o,
  output logic                                             axi_wlast_o,
  output logic                                             axi_wvalid_o,
  input  logic                                             axi_wready_i,
  // AXI write response
  input  logic [axi_id_width_p-1:0]                        axi_bid_i,
  input  logic [1:0]                                       axi_bresp_i,
  input  logic                                             axi_bvalid_i,
  output logic                                             axi_bready_o,
  // AXI read address
  output logic [axi_id_width_p-1:0]                        axi_arid_o,
  output logic [axi_addr_width_p-1:0]                      axi_araddr_o,
  output logic [7:0]                                       axi_arlen_o,
  output logic [2:0]                                       axi_arsize_o,
  output logic [1:0]                                       axi_arburst_o,
  output logic                                             axi_arvalid_o,
  input  logic                                             axi_arready_i,
  // AXI read data
  input  logic [axi_id_width_p-1:0]                        axi_rid_i,
  input  logic [axi_data_width_p-1:0]                      axi_rdata_i,
  input  logic [1:0]                                       axi_rresp_i,
  input  logic                                             axi_rlast_i,
  input  logic                                             axi_rvalid_i,
  output logic                                             axi_rready_o
);

  localparam int unsigned lg_clients_lp = $clog2(num_clients_p);
  localparam int unsigned cand_w_lp     = lg_clients_lp + 1;
  localparam int unsigned cnt_w_lp      = (axi_burst_len_p > 1) ? $clog2(axi_burst_len_p) : 1;
  localparam int unsigned size_lp       = $clog2(axi_data_width_p / 8);
  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(axi_burst_len_p - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrData,
    StWrResp
  } state_e;

  state_e                        state_q, state_d;
  logic [lg_clients_lp-1:0]      gnt_q, gnt_d;
  logic [lg_clients_lp-1:0]      last_q, last_d;
  logic                          we_q, we_d;
  logic [axi_addr_width_p-1:0]   addr_q, addr_d;
  logic [cnt_w_lp-1:0]           cnt_q, cnt_d;
  logic                          error_q, error_d;

  logic                          arb_found;
  logic [lg_clients_lp-1:0]      arb_idx;
  logic [axi_id_width_p-1:0]     gnt_id;

  assign gnt_id = axi_id_width_p'(gnt_q);

  // Round-robin pick: first requester at or after last_q+1, wrapping.
  always_comb begin
    logic [cand_w_lp-1:0]     cand;
    logic [lg_clients_lp-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= num_clients_p; i++) begin
      cand = {1'b0, last_q} + cand_w_lp'(i);
      if (cand >= cand_w_lp'(num_clients_p)) begin
        cand = cand - cand_w_lp'(num_clients_p);
      end
      cand_idx = cand[lg_clients_lp-1:0];
      if (!arb_found && req_v_i[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Next-state logic and all client/AXI outputs.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    error_d = error_q;

    req_ready_o   = '0;
    wdata_ready_o = '0;
    rdata_v_o     = '0;
    rdata_o       = '0;
    wr_done_o     = '0;
    error_o       = error_q;

    axi_awid_o    = gnt_id;
    axi_awaddr_o  = addr_q;
    axi_awlen_o   = 8'(axi_burst_len_p - 1);
    axi_awsize_o  = 3'(size_lp);
    axi_awburst_o = 2'b01;
    axi_awvalid_o = 1'b0;
    axi_wdata_o   = '0;
    axi_wstrb_o   = '1;
    axi_wlast_o   = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_bready_o  = 1'b0;
    axi_arid_o    = gnt_id;
    axi_araddr_o  = addr_q;
    axi_arlen_o   = 8'(axi_burst_len_p - 1);
    axi_arsize_o  = 3'(size_lp);
    axi_arburst_o = 2'b01;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // reset_i gating keeps the combinational accept low while the block is held in reset
        if (arb_found && !reset_i) begin
          req_ready_o[arb_idx] = 1'b1;
          gnt_d   = arb_idx;
          last_d  = arb_idx;
          we_d    = req_we_i[arb_idx];
          addr_d  = req_addr_i[arb_idx];
          state_d = req_we_i[arb_idx] ? StWrAddr : StRdAddr;
        end
      end
      StRdAddr: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) begin
          state_d = StRdData;
          cnt_d   = '0;
        end
      end
      StRdData: begin
        rdata_v_o[gnt_q] = axi_rvalid_i;
        axi_rready_o     = rdata_ready_i[gnt_q];
        rdata_o          = axi_rdata_i;
        if (axi_rvalid_i && rdata_ready_i[gnt_q]) begin
          cnt_d = cnt_q + cnt_w_lp'(1);
          if ((axi_rresp_i != 2'b00) || (axi_rid_i != gnt_id) ||
              (axi_rlast_i != (cnt_q == last_beat_lp))) begin
            error_d = 1'b1;
          end
          if (axi_rlast_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      StWrAddr: begin
        axi_awvalid_o = 1'b1;
        if (axi_awready_i) begin
          state_d = StWrData;
          cnt_d   = '0;
        end
      end
      StWrData: begin
        axi_wvalid_o         = wdata_v_i[gnt_q];
        wdata_ready_o[gnt_q] = axi_wready_i;
        axi_wdata_o          = wdata_i[gnt_q];
        axi_wlast_o          = (cnt_q == last_beat_lp);
        if (wdata_v_i[gnt_q] && axi_wready_i) begin
          if (cnt_q == last_beat_lp) begin
            state_d = StWrResp;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
      end
      StWrResp: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) begin
          wr_done_o[gnt_q] = 1'b1;
          if ((axi_bresp_i != 2'b00) || (axi_bid_i != gnt_id)) begin
            error_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= lg_clients_lp'(num_clients_p - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

endmodule
